// File: rtl/vpu_pkg.sv
// Shared constants, ALU op encodings and issue-stage FSM states for the vector unit.
package vpu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } issue_state_e;

endpackage

// File: rtl/vpu_sync_fifo.sv
// Single-clock FIFO with registered head (no bypass), synchronous flush and occupancy count.
module vpu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; validity is tracked entirely by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/valu_issue_stage.sv
// Feeds operand/op triples from three queues to the VALU and registers its result toward writeback.
module valu_issue_stage
    import vpu_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = vpu_pkg::DATA_W,
    parameter int OP_W   = vpu_pkg::OP_W,
    parameter int VL_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_push_valid,
    input  logic [DATA_W-1:0] a_push_data,
    output logic              a_push_ready,
    input  logic              b_push_valid,
    input  logic [DATA_W-1:0] b_push_data,
    output logic              b_push_ready,
    input  logic              op_push_valid,
    input  logic [OP_W-1:0]   op_push_data,
    output logic              op_push_ready,
    input  logic              start,
    input  logic [VL_W-1:0]   vl,
    input  logic              flush,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_ans,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [VL_W-1:0]   res_idx,
    output logic              res_last,
    input  logic              res_ready,
    output logic              busy,
    output logic              done
);

    issue_state_e      state;
    logic [VL_W-1:0]   vl_q;
    logic [VL_W-1:0]   issue_cnt;
    logic              a_full, b_full, op_full;
    logic              a_empty, b_empty, op_empty;
    logic [DATA_W-1:0] a_head, b_head;
    logic [OP_W-1:0]   op_head;
    logic              fire;
    logic              is_last;

    vpu_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_a_fifo (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .push(a_push_valid), .push_data(a_push_data), .pop(fire),
        .head(a_head), .full(a_full), .empty(a_empty)
    );

    vpu_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_b_fifo (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .push(b_push_valid), .push_data(b_push_data), .pop(fire),
        .head(b_head), .full(b_full), .empty(b_empty)
    );

    vpu_sync_fifo #(.WIDTH(OP_W), .DEPTH(DEPTH)) u_op_fifo (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .push(op_push_valid), .push_data(op_push_data), .pop(fire),
        .head(op_head), .full(op_full), .empty(op_empty)
    );

    assign a_push_ready  = !a_full;
    assign b_push_ready  = !b_full;
    assign op_push_ready = !op_full;

    assign alu_a  = a_empty  ? '0 : a_head;
    assign alu_b  = b_empty  ? '0 : b_head;
    assign alu_op = op_empty ? '0 : op_head;

    assign fire    = (state == RUN) && !a_empty && !b_empty && !op_empty
                     && (!res_valid || res_ready);
    assign is_last = (issue_cnt == vl_q - VL_W'(1));
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            vl_q      <= '0;
            issue_cnt <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            res_last  <= 1'b0;
            done      <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            issue_cnt <= '0;
            res_valid <= 1'b0;
            res_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (fire) begin
                res_valid <= 1'b1;
                res_data  <= alu_ans;
                res_idx   <= issue_cnt;
                res_last  <= is_last;
                issue_cnt <= issue_cnt + VL_W'(1);
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        if (vl != '0) begin
                            vl_q      <= vl;
                            issue_cnt <= '0;
                            state     <= RUN;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire && is_last) state <= DRAIN;
                end
                DRAIN: begin
                    // Last result was captured on entry; leave once writeback takes it.
                    if (res_valid && res_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_valu_issue_stage.sv
// Directed self-checking bench for valu_issue_stage with a behavioural VALU model.
module tb_valu_issue_stage;
    import vpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_push_valid, b_push_valid, op_push_valid;
    logic [31:0] a_push_data, b_push_data;
    logic [2:0]  op_push_data;
    logic        a_push_ready, b_push_ready, op_push_ready;
    logic        start, flush, res_ready;
    logic [7:0]  vl;
    logic [31:0] alu_a, alu_b, alu_ans, res_data;
    logic [2:0]  alu_op;
    logic        res_valid, res_last, busy, done;
    logic [7:0]  res_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_ans = '1;
        case (alu_op)
            3'd0: alu_ans = alu_a + alu_b;
            3'd1: alu_ans = alu_a - alu_b;
            3'd2: alu_ans = alu_a & alu_b;
            3'd3: alu_ans = alu_a | alu_b;
            3'd4: alu_ans = alu_a ^ alu_b;
            default: alu_ans = '1;
        endcase
    end

    valu_issue_stage #(.DEPTH(8), .DATA_W(32), .OP_W(3), .VL_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_push_valid(a_push_valid), .a_push_data(a_push_data), .a_push_ready(a_push_ready),
        .b_push_valid(b_push_valid), .b_push_data(b_push_data), .b_push_ready(b_push_ready),
        .op_push_valid(op_push_valid), .op_push_data(op_push_data), .op_push_ready(op_push_ready),
        .start(start), .vl(vl), .flush(flush),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ans(alu_ans),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx), .res_last(res_last),
        .res_ready(res_ready), .busy(busy), .done(done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic va, input logic [31:0] a, input logic vb, input logic [31:0] b,
                        input logic vo, input logic [2:0] o);
        a_push_valid = va; a_push_data = a;
        b_push_valid = vb; b_push_data = b;
        op_push_valid = vo; op_push_data = o;
        tick();
        a_push_valid = 1'b0; b_push_valid = 1'b0; op_push_valid = 1'b0;
    endtask

    task automatic begin_op(input logic [7:0] len);
        start = 1'b1; vl = len;
        tick();
        start = 1'b0; vl = '0;
    endtask

    task automatic test_reset();
        push(1'b1, 32'd1, 1'b0, 32'd0, 1'b0, 3'd0);
        push(1'b1, 32'd2, 1'b0, 32'd0, 1'b0, 3'd0);
        push(1'b1, 32'd3, 1'b0, 32'd0, 1'b0, 3'd0);
        begin_op(8'd4);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_prebusy got %0b exp 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if ({res_valid, res_last, busy, done} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags got %b exp 0000", {res_valid, res_last, busy, done}); end
        checks++; if (res_data !== 32'd0 || res_idx !== 8'd0) begin errors++;
            $display("FAIL reset_res got data %0h idx %0d exp 0 0", res_data, res_idx); end
        checks++; if ({a_push_ready, b_push_ready, op_push_ready} !== 3'b111) begin errors++;
            $display("FAIL reset_ready got %b exp 111", {a_push_ready, b_push_ready, op_push_ready}); end
        checks++; if (alu_a !== 32'd0 || dut.u_a_fifo.count !== 4'd0) begin errors++;
            $display("FAIL reset_qempty got alu_a %0h count %0d exp 0 0", alu_a, dut.u_a_fifo.count); end
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [3] = '{32'd8, 32'd6, 32'd5};
        int done_cnt = 0;
        push(1'b1, 32'd5,  1'b1, 32'd3, 1'b1, ALU_ADD);
        push(1'b1, 32'd10, 1'b1, 32'd4, 1'b1, ALU_SUB);
        push(1'b1, 32'd7,  1'b1, 32'd2, 1'b1, ALU_XOR);
        res_ready = 1'b1;
        begin_op(8'd3);
        for (int unsigned i = 0; i < 3; i++) begin
            tick();
            if (done) done_cnt++;
            checks++; if (res_valid !== 1'b1 || res_data !== exp_d[i] || res_idx !== 8'(i)
                          || res_last !== (i == 2)) begin errors++;
                $display("FAIL basic_res%0d got v%0b d%0d i%0d l%0b exp v1 d%0d i%0d l%0b",
                         i, res_valid, res_data, res_idx, res_last, exp_d[i], i, (i == 2)); end
        end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0) begin errors++;
            $display("FAIL basic_done got done%0b busy%0b v%0b exp 1 0 0", done, busy, res_valid); end
        if (done) done_cnt++;
        tick();
        if (done) done_cnt++;
        checks++; if (done_cnt !== 1) begin errors++;
            $display("FAIL basic_done_once got %0d pulses exp 1", done_cnt); end
    endtask

    task automatic test_stall();
        push(1'b1, 32'd1, 1'b1, 32'd1, 1'b1, ALU_ADD);
        push(1'b1, 32'd2, 1'b1, 32'd1, 1'b1, ALU_ADD);
        res_ready = 1'b1;
        begin_op(8'd2);
        tick();
        res_ready = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            tick();
            checks++; if (res_valid !== 1'b1 || res_data !== 32'd2 || res_idx !== 8'd0
                          || dut.u_a_fifo.count !== 4'd1) begin errors++;
                $display("FAIL stall_hold%0d got v%0b d%0d i%0d cnt%0d exp 1 2 0 1",
                         i, res_valid, res_data, res_idx, dut.u_a_fifo.count); end
        end
        res_ready = 1'b1;
        tick();
        checks++; if (res_data !== 32'd3 || res_idx !== 8'd1 || res_last !== 1'b1) begin errors++;
            $display("FAIL stall_second got d%0d i%0d l%0b exp 3 1 1", res_data, res_idx, res_last); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL stall_done got %0b exp 1", done); end
        tick();
    endtask

    task automatic test_skew();
        logic [31:0] b_vals [3] = '{32'd10, 32'd20, 32'd30};
        for (int unsigned i = 0; i < 8; i++) push(1'b1, 32'(i + 1), 1'b0, 32'd0, 1'b1, ALU_ADD);
        checks++; if (a_push_ready !== 1'b0 || op_push_ready !== 1'b0) begin errors++;
            $display("FAIL skew_full got a%0b op%0b exp 0 0", a_push_ready, op_push_ready); end
        push(1'b1, 32'd99, 1'b0, 32'd0, 1'b0, 3'd0);
        checks++; if (dut.u_a_fifo.count !== 4'd8) begin errors++;
            $display("FAIL skew_drop got count %0d exp 8", dut.u_a_fifo.count); end
        res_ready = 1'b1;
        begin_op(8'd3);
        for (int unsigned k = 0; k < 3; k++) begin
            push(1'b0, 32'd0, 1'b1, b_vals[k], 1'b0, 3'd0);
            tick();
            checks++; if (res_valid !== 1'b1 || res_data !== 32'(k + 1) + b_vals[k] || res_idx !== 8'(k))
                begin errors++;
                $display("FAIL skew_res%0d got v%0b d%0d i%0d exp 1 %0d %0d",
                         k, res_valid, res_data, res_idx, 32'(k + 1) + b_vals[k], k); end
            tick();
            checks++; if (res_valid !== 1'b0) begin errors++;
                $display("FAIL skew_gap%0d got v%0b exp 0", k, res_valid); end
        end
        checks++; if (done !== 1'b1 || alu_a !== 32'd4 || dut.u_a_fifo.count !== 4'd5) begin errors++;
            $display("FAIL skew_left got done%0b alu_a%0d cnt%0d exp 1 4 5", done, alu_a, dut.u_a_fifo.count); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic test_boundary();
        begin_op(8'd0);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL vl0_done got done%0b busy%0b exp 1 0", done, busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL vl0_after got done%0b busy%0b exp 0 0", done, busy); end
        push(1'b1, 32'd3, 1'b1, 32'd4, 1'b1, ALU_AND);
        push(1'b1, 32'd6, 1'b1, 32'd3, 1'b1, ALU_OR);
        res_ready = 1'b0;
        begin_op(8'd2);
        tick();
        begin_op(8'd5);
        checks++; if (res_data !== 32'd0 || res_idx !== 8'd0 || busy !== 1'b1) begin errors++;
            $display("FAIL ign_first got d%0d i%0d busy%0b exp 0 0 1", res_data, res_idx, busy); end
        res_ready = 1'b1;
        tick();
        checks++; if (res_data !== 32'd7 || res_idx !== 8'd1 || res_last !== 1'b1) begin errors++;
            $display("FAIL ign_second got d%0d i%0d l%0b exp 7 1 1", res_data, res_idx, res_last); end
        tick();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL ign_done got done%0b busy%0b exp 1 0", done, busy); end
        tick();
    endtask

    task automatic test_flush();
        for (int unsigned i = 0; i < 4; i++) push(1'b1, 32'(i + 1), 1'b1, 32'd0, 1'b1, ALU_ADD);
        res_ready = 1'b1;
        begin_op(8'd4);
        tick();
        checks++; if (res_data !== 32'd1 || res_valid !== 1'b1) begin errors++;
            $display("FAIL flush_pre got d%0d v%0b exp 1 1", res_data, res_valid); end
        flush = 1'b1;
        a_push_valid = 1'b1; a_push_data = 32'h55;
        tick();
        flush = 1'b0; a_push_valid = 1'b0;
        checks++; if ({res_valid, busy, done} !== 3'b000) begin errors++;
            $display("FAIL flush_state got %b exp 000", {res_valid, busy, done}); end
        checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0 || alu_op !== 3'd0 || dut.u_a_fifo.count !== 4'd0)
            begin errors++;
            $display("FAIL flush_q got a%0h b%0h op%0d cnt%0d exp 0 0 0 0", alu_a, alu_b, alu_op,
                     dut.u_a_fifo.count); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL flush_nodone got %0b exp 0", done); end
        push(1'b1, 32'hFFFF_FFFF, 1'b1, 32'd1, 1'b1, ALU_ADD);
        begin_op(8'd1);
        tick();
        checks++; if (res_valid !== 1'b1 || res_data !== 32'd0 || res_idx !== 8'd0 || res_last !== 1'b1)
            begin errors++;
            $display("FAIL flush_new got v%0b d%0h i%0d l%0b exp 1 0 0 1", res_valid, res_data, res_idx,
                     res_last); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL flush_new_done got %0b exp 1", done); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        a_push_valid = 1'b0; a_push_data = '0;
        b_push_valid = 1'b0; b_push_data = '0;
        op_push_valid = 1'b0; op_push_data = '0;
        start = 1'b0; vl = '0; flush = 1'b0; res_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        test_reset();
        test_basic();
        test_stall();
        test_skew();
        test_boundary();
        test_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
